// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP_RISC control unit: opcodes, ALU/branch fcodes,
// FSM states and flag bit positions.
package kgp_ctrl_pkg;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_IMM   = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BR    = 3'b100;

    localparam logic [3:0] FC_ADD   = 4'b0000;
    localparam logic [3:0] FC_COMP  = 4'b0001;
    localparam logic [3:0] FC_AND   = 4'b0010;
    localparam logic [3:0] FC_XOR   = 4'b0011;
    localparam logic [3:0] FC_SHLL  = 4'b0100;
    localparam logic [3:0] FC_SHRL  = 4'b0101;
    localparam logic [3:0] FC_SHLLV = 4'b0110;
    localparam logic [3:0] FC_SHRLV = 4'b0111;
    localparam logic [3:0] FC_SHRA  = 4'b1000;
    localparam logic [3:0] FC_SHRAV = 4'b1001;
    localparam logic [3:0] FC_MULT  = 4'b1010;
    localparam logic [3:0] FC_MULTU = 4'b1011;

    localparam logic [3:0] FC_ADDI  = 4'b0000;
    localparam logic [3:0] FC_COMPI = 4'b0001;

    localparam logic [3:0] BR_ALWAYS = 4'b0000;
    localparam logic [3:0] BR_Z      = 4'b0001;
    localparam logic [3:0] BR_NZ     = 4'b0010;
    localparam logic [3:0] BR_C      = 4'b0011;
    localparam logic [3:0] BR_NC     = 4'b0100;
    localparam logic [3:0] BR_S      = 4'b0101;
    localparam logic [3:0] BR_NS     = 4'b0110;
    localparam logic [3:0] BR_O      = 4'b0111;
    localparam logic [3:0] BR_NO     = 4'b1000;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    // R-type fcodes run contiguously from ADD up to MULTU; anything above traps.
    function automatic logic instr_legal(input logic [2:0] op, input logic [3:0] fc,
                                         input logic br_legal);
        case (op)
            OP_RTYPE:    return fc <= FC_MULTU;
            OP_IMM:      return fc <= FC_COMPI;
            OP_LW, OP_SW: return 1'b1;
            OP_BR:       return br_legal;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kgp_control_fsm_branch_cond.sv
// Branch condition evaluation against the registered {C,Z,S,O} flags.
module kgp_branch_cond
    import kgp_ctrl_pkg::*;
(
    input  logic [3:0] fcode,
    input  logic [3:0] flags,
    output logic       taken,
    output logic       legal
);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (fcode)
            BR_ALWAYS: taken = 1'b1;
            BR_Z:      taken = flags[FLAG_Z];
            BR_NZ:     taken = ~flags[FLAG_Z];
            BR_C:      taken = flags[FLAG_C];
            BR_NC:     taken = ~flags[FLAG_C];
            BR_S:      taken = flags[FLAG_S];
            BR_NS:     taken = ~flags[FLAG_S];
            BR_O:      taken = flags[FLAG_O];
            BR_NO:     taken = ~flags[FLAG_O];
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/kgp_control_fsm.sv
// Multi-cycle control unit: fetch/decode/exec/mem/wb sequencing, PC, IR and
// architectural flag register for the KGP_RISC core.
module kgp_control_fsm
    import kgp_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] pc,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_s,
    input  logic        alu_o,
    output logic [2:0]  alu_opcode,
    output logic [3:0]  alu_fcode,
    output logic        alu_src_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rd_addr,
    output logic        reg_we,
    output logic        reg_we_hi,
    output logic        wb_sel,
    output logic [3:0]  flags,
    output logic        halted
);

    state_t      state, state_nx;
    logic [31:0] ir;
    logic [31:0] pc_nx;
    logic        ir_load, flags_load, pc_load;
    logic        br_taken, br_legal;

    wire [2:0]  op         = ir[31:29];
    wire [3:0]  fc         = ir[28:25];
    wire [31:0] pc_plus4   = pc + 32'd4;
    wire [31:0] br_target  = pc_plus4 + {{5{ir[24]}}, ir[24:0], 2'b00};
    wire        is_sw      = (op == OP_SW);

    assign imm     = {{16{ir[15]}}, ir[15:0]};
    assign rs_addr = ir[24:20];
    assign rt_addr = ir[19:15];
    assign rd_addr = ir[14:10];

    kgp_branch_cond u_branch_cond (
        .fcode (fc),
        .flags (flags),
        .taken (br_taken),
        .legal (br_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
            flags <= '0;
        end else begin
            state <= state_nx;
            if (ir_load)    ir    <= imem_rdata;
            if (flags_load) flags <= {alu_c, alu_z, alu_s, alu_o};
            if (pc_load)    pc    <= pc_nx;
        end
    end

    // Strobes depend only on state and ir; acks and ALU flags feed registers only.
    always_comb begin
        state_nx    = state;
        ir_load     = 1'b0;
        flags_load  = 1'b0;
        pc_load     = 1'b0;
        pc_nx       = pc_plus4;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_we      = 1'b0;
        reg_we_hi   = 1'b0;
        wb_sel      = 1'b0;
        halted      = 1'b0;
        alu_opcode  = 3'b000;
        alu_fcode   = 4'b0000;
        alu_src_imm = 1'b0;
        case (state)
            ST_IDLE: state_nx = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load  = 1'b1;
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: state_nx = instr_legal(op, fc, br_legal) ? ST_EXEC : ST_HALT;
            ST_EXEC: begin
                case (op)
                    OP_RTYPE, OP_IMM: begin
                        alu_opcode  = op;
                        alu_fcode   = fc;
                        alu_src_imm = (op == OP_IMM);
                        flags_load  = 1'b1;
                        state_nx    = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_opcode  = OP_IMM;
                        alu_fcode   = FC_ADDI;
                        alu_src_imm = 1'b1;
                        state_nx    = ST_MEM;
                    end
                    default: begin
                        // Only branches reach here; the ALU is left idle.
                        pc_load  = 1'b1;
                        pc_nx    = br_taken ? br_target : pc_plus4;
                        state_nx = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ack) begin
                    if (is_sw) begin
                        pc_load  = 1'b1;
                        state_nx = ST_FETCH;
                    end else begin
                        state_nx = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we    = 1'b1;
                wb_sel    = (op == OP_LW);
                reg_we_hi = (op == OP_RTYPE) && (fc == FC_MULT || fc == FC_MULTU);
                pc_load   = 1'b1;
                state_nx  = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Bench for kgp_control_fsm: per-cycle expectations built from an
// instruction-level model, directed table plus randomized instruction stream.
module tb_kgp_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] pc;
    logic        dmem_ack = 1'b0;
    logic        dmem_req, dmem_we;
    logic        alu_c = 1'b0, alu_z = 1'b0, alu_s = 1'b0, alu_o = 1'b0;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_fcode;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        reg_we, reg_we_hi, wb_sel;
    logic [3:0]  flags;
    logic        halted;

    kgp_control_fsm dut (
        .clk(clk), .rst(rst), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .pc(pc), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .alu_c(alu_c), .alu_z(alu_z), .alu_s(alu_s), .alu_o(alu_o),
        .alu_opcode(alu_opcode), .alu_fcode(alu_fcode), .alu_src_imm(alu_src_imm),
        .imm(imm), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .reg_we(reg_we), .reg_we_hi(reg_we_hi), .wb_sel(wb_sel), .flags(flags),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // One clock cycle: inputs to drive, outputs expected during that cycle.
    typedef struct {
        logic        iack;
        logic [31:0] rdata;
        logic        dack;
        logic [3:0]  aflags;
        logic        imem_req, dmem_req, dmem_we, reg_we, reg_we_hi, wb_sel, halted;
        logic [2:0]  alu_op;
        logic [3:0]  alu_fc;
        logic        src_imm;
        logic [31:0] pc;
        logic [3:0]  flags;
        logic [31:0] ir;
    } vec_t;

    typedef struct {
        bit          rst_before;
        logic [31:0] instr;
        int          iw;
        int          dw;
        logic [3:0]  af;
        logic [31:0] exp_pc;
        logic [3:0]  exp_flags;
        logic        exp_halt;
    } dir_t;

    vec_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          step = 0;
    logic [31:0] mpc, mir;
    logic [3:0]  mflags;
    logic        mhalt;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h exp=%h", name, step, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [2:0] op, input logic [3:0] fc,
                                        input logic [24:0] lo);
        return {op, fc, lo};
    endfunction

    function automatic bit is_legal(input logic [31:0] w);
        int op = int'(w[31:29]);
        int fc = int'(w[28:25]);
        if (op == 0) return fc <= 11;
        if (op == 1) return fc <= 1;
        if (op == 2 || op == 3) return 1'b1;
        if (op == 4) return fc <= 8;
        return 1'b0;
    endfunction

    function automatic bit cond_true(input int fc, input logic [3:0] f);
        bit c = f[3], z = f[2], s = f[1], o = f[0];
        case (fc)
            0: return 1'b1;
            1: return z;
            2: return !z;
            3: return c;
            4: return !c;
            5: return s;
            6: return !s;
            7: return o;
            8: return !o;
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t base();
        vec_t v;
        v.iack = 1'($urandom_range(0, 1));
        v.rdata = $urandom;
        v.dack = 1'($urandom_range(0, 1));
        v.aflags = 4'($urandom_range(0, 15));
        v.imem_req = 0; v.dmem_req = 0; v.dmem_we = 0; v.reg_we = 0;
        v.reg_we_hi = 0; v.wb_sel = 0; v.halted = mhalt;
        v.alu_op = 0; v.alu_fc = 0; v.src_imm = 0;
        v.pc = mpc; v.flags = mflags; v.ir = mir;
        return v;
    endfunction

    task automatic check_vec(input vec_t v);
        logic [31:0] eimm = {{16{v.ir[15]}}, v.ir[15:0]};
        chk("strobes", 64'({imem_req, dmem_req, dmem_we, reg_we, reg_we_hi, wb_sel, halted}),
            64'({v.imem_req, v.dmem_req, v.dmem_we, v.reg_we, v.reg_we_hi, v.wb_sel, v.halted}));
        chk("alu", 64'({alu_opcode, alu_fcode, alu_src_imm}), 64'({v.alu_op, v.alu_fc, v.src_imm}));
        chk("pc", 64'(pc), 64'(v.pc));
        chk("flags", 64'(flags), 64'(v.flags));
        chk("fields", 64'({rs_addr, rt_addr, rd_addr, imm}),
            64'({v.ir[24:20], v.ir[19:15], v.ir[14:10], eimm}));
    endtask

    task automatic gen_instr(input logic [31:0] w, input int iw, input int dw, input logic [3:0] af);
        vec_t v;
        int op = int'(w[31:29]);
        int fc = int'(w[28:25]);
        logic signed [31:0] off = {{7{w[24]}}, w[24:0]};
        for (int i = 0; i < iw; i++) begin
            v = base(); v.iack = 0; v.imem_req = 1; q.push_back(v);
        end
        v = base(); v.iack = 1; v.rdata = w; v.imem_req = 1; q.push_back(v);
        mir = w;
        v = base(); q.push_back(v);
        if (!is_legal(w)) begin
            mhalt = 1;
            for (int i = 0; i < 4; i++) begin
                v = base(); q.push_back(v);
            end
            return;
        end
        v = base(); v.aflags = af;
        if (op <= 1) begin
            v.alu_op = 3'(op); v.alu_fc = 4'(fc); v.src_imm = (op == 1); q.push_back(v);
            mflags = af;
            v = base(); v.reg_we = 1; v.reg_we_hi = (op == 0 && (fc == 10 || fc == 11));
            q.push_back(v);
            mpc = mpc + 4;
        end else if (op <= 3) begin
            v.alu_op = 3'd1; v.alu_fc = 4'd0; v.src_imm = 1; q.push_back(v);
            for (int i = 0; i <= dw; i++) begin
                v = base(); v.dack = (i == dw); v.dmem_req = 1; v.dmem_we = (op == 3);
                q.push_back(v);
            end
            if (op == 2) begin
                v = base(); v.reg_we = 1; v.wb_sel = 1; q.push_back(v);
            end
            mpc = mpc + 4;
        end else begin
            q.push_back(v);
            mpc = cond_true(fc, mflags) ? mpc + 32'd4 + 32'(off * 4) : mpc + 32'd4;
        end
    endtask

    task automatic run_queue();
        vec_t v;
        while (q.size() > 0) begin
            v = q.pop_front();
            @(negedge clk);
            step++;
            check_vec(v);
            imem_ack = v.iack; imem_rdata = v.rdata; dmem_ack = v.dack;
            {alu_c, alu_z, alu_s, alu_o} = v.aflags;
        end
    endtask

    // Asserts reset mid-cycle with stray acks present, checks it acts at once.
    task automatic do_reset();
        vec_t v;
        @(negedge clk);
        rst = 1; imem_ack = 1; dmem_ack = 1;
        mpc = 0; mir = 0; mflags = 0; mhalt = 0;
        #1;
        step++;
        v = base();
        check_vec(v);
        @(negedge clk);
        step++;
        check_vec(v);
        rst = 0; imem_ack = 0; dmem_ack = 0;
    endtask

    task automatic end_check(input string name, input logic [31:0] epc, input logic [3:0] ef,
                             input logic eh);
        @(posedge clk);
        #1;
        chk({name, "_pc"}, 64'(pc), 64'(epc));
        chk({name, "_flags"}, 64'(flags), 64'(ef));
        chk({name, "_halt"}, 64'(halted), 64'(eh));
    endtask

    dir_t tbl[16];

    initial begin
        tbl[0]  = '{1'b1, ins(3'd1, 4'h0, {5'd0, 5'd1, 15'd5}), 0, 0, 4'b0000, 32'd4, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, ins(3'd0, 4'h0, {5'd2, 5'd3, 5'd4, 10'd0}), 0, 0, 4'b0100, 32'd4, 4'b0100, 1'b0};
        tbl[2]  = '{1'b0, ins(3'd4, 4'h1, 25'd3), 0, 0, 4'b1011, 32'd20, 4'b0100, 1'b0};
        tbl[3]  = '{1'b0, ins(3'd4, 4'h2, 25'd3), 2, 0, 4'b0000, 32'd24, 4'b0100, 1'b0};
        tbl[4]  = '{1'b0, ins(3'd2, 4'h0, {5'd1, 5'd7, 15'h7ff8}), 0, 3, 4'b1111, 32'd28, 4'b0100, 1'b0};
        tbl[5]  = '{1'b0, ins(3'd3, 4'h0, {5'd1, 5'd7, 15'h0010}), 1, 0, 4'b1111, 32'd32, 4'b0100, 1'b0};
        tbl[6]  = '{1'b0, ins(3'd0, 4'hB, {5'd5, 5'd6, 5'd7, 10'd0}), 0, 0, 4'b1001, 32'd36, 4'b1001, 1'b0};
        tbl[7]  = '{1'b0, ins(3'd4, 4'h3, 25'h1FFFFF7), 0, 0, 4'b0000, 32'd4, 4'b1001, 1'b0};
        tbl[8]  = '{1'b0, ins(3'd4, 4'h0, 25'h1FFFFFF), 0, 0, 4'b0000, 32'd4, 4'b1001, 1'b0};
        tbl[9]  = '{1'b0, ins(3'd1, 4'h1, {5'd3, 5'd4, 15'h4321}), 0, 0, 4'b0010, 32'd8, 4'b0010, 1'b0};
        tbl[10] = '{1'b0, ins(3'd6, 4'h0, 25'd0), 0, 0, 4'b1111, 32'd8, 4'b0010, 1'b1};
        tbl[11] = '{1'b1, ins(3'd4, 4'h0, 25'h1FFFFFE), 0, 0, 4'b1111, 32'hFFFFFFFC, 4'b0000, 1'b0};
        tbl[12] = '{1'b0, ins(3'd1, 4'h0, 25'd1), 1, 0, 4'b0000, 32'd0, 4'b0000, 1'b0};
        tbl[13] = '{1'b0, ins(3'd0, 4'hF, 25'd0), 0, 0, 4'b0000, 32'd0, 4'b0000, 1'b1};
        tbl[14] = '{1'b1, ins(3'd1, 4'h2, 25'd0), 0, 0, 4'b0000, 32'd0, 4'b0000, 1'b1};
        tbl[15] = '{1'b1, ins(3'd4, 4'h9, 25'd0), 0, 0, 4'b0000, 32'd0, 4'b0000, 1'b1};

        mpc = 0; mir = 0; mflags = 0; mhalt = 0;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst_before) do_reset();
            gen_instr(tbl[i].instr, tbl[i].iw, tbl[i].dw, tbl[i].af);
            run_queue();
            end_check($sformatf("tbl%0d", i), tbl[i].exp_pc, tbl[i].exp_flags, tbl[i].exp_halt);
        end

        // Reset while a fetch is pending, then a clean fetch from 0.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            vec_t v;
            v = base(); v.iack = 0; v.imem_req = 1; q.push_back(v);
        end
        run_queue();
        do_reset();
        gen_instr(ins(3'd1, 4'h0, 25'd9), 0, 0, 4'b0000);
        run_queue();
        end_check("refetch", 32'd4, 4'b0000, 1'b0);

        // Random legal instruction stream, ending in an illegal opcode.
        do_reset();
        for (int n = 0; n < 200; n++) begin
            int r = $urandom_range(0, 99);
            logic [31:0] w = $urandom;
            if (r < 30)      w[31:25] = {3'd0, 4'($urandom_range(0, 11))};
            else if (r < 45) w[31:25] = {3'd1, 4'($urandom_range(0, 1))};
            else if (r < 60) w[31:29] = 3'd2;
            else if (r < 72) w[31:29] = 3'd3;
            else             w[31:25] = {3'd4, 4'($urandom_range(0, 8))};
            gen_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom_range(0, 15)));
            run_queue();
        end
        begin
            logic [31:0] w = $urandom;
            w[31:29] = 3'($urandom_range(5, 7));
            gen_instr(w, $urandom_range(0, 2), 0, 4'b0000);
            run_queue();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
